// File: rtl/calc_memory.sv
// Storage and execute end of the keypad calculator's controller-to-memory link.
// Builds decimal operands A and B from keypad digits and holds the opcode.
// On "equals" it produces R: add/sub/mul in one cycle, divide iteratively.
// dispValue shows R while a fresh result is held, otherwise the selected register.
module calc_memory #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memClr,
    input  logic             memSet,
    input  logic [1:0]       memLoc,
    input  logic [1:0]       memDisplay,
    input  logic [3:0]       keyValue,
    output logic [WIDTH-1:0] dispValue,
    output logic [1:0]       opcode,
    output logic             busy,
    output logic             resultValid,
    output logic             error
);

    // Digit entry is evaluated wide enough that reg*10+9 can never wrap.
    localparam int TW = 2 * WIDTH + 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, r_reg;
    logic [1:0]       opcode_reg;
    logic             error_reg, valid_reg;
    logic             set_q, clr_q;
    logic [WIDTH-1:0] rem_reg, quo_reg;
    logic [CW-1:0]    cnt_reg;
    logic             div_pending_reg;

    // Command decode: rising edges of the controller levels.
    logic set_edge, clr_edge;
    logic clear_cmd, equals_cmd, write_cmd;

    assign set_edge   = memSet & ~set_q;
    assign clr_edge   = memClr & ~clr_q;
    // A clear is honoured in every state, including mid-divide (abort).
    assign clear_cmd  = clr_edge && (memLoc != 2'b11);
    assign equals_cmd = clr_edge && (memLoc == 2'b11) && (state_reg == IDLE);
    // Clear/equals on the same edge wins; the write is dropped.
    assign write_cmd  = set_edge && !clr_edge && (state_reg == IDLE);

    // Digit accumulation: t = reg*10 + key, checked against MAX.
    logic [TW-1:0] digit_src, digit_t;
    logic          digit_ok, digit_fits;

    assign digit_src  = memLoc[0] ? TW'(b_reg) : TW'(a_reg);
    assign digit_t    = digit_src * TW'(10) + TW'(keyValue);
    assign digit_ok   = (keyValue <= 4'd9);
    assign digit_fits = (digit_t <= TW'(MAX));

    // Single-cycle ALU with saturation and error flagging.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_err;
    logic               div_start;

    assign sum       = {1'b0, a_reg} + {1'b0, b_reg};
    assign prod      = (2*WIDTH)'(a_reg) * (2*WIDTH)'(b_reg);
    assign div_start = (opcode_reg == 2'b11) && (b_reg != '0);

    // Result and error selection for the one-cycle equals path.
    always_comb begin
        alu_result = '0;
        alu_err    = 1'b0;
        case (opcode_reg)
            2'b00: begin
                if (sum[WIDTH]) begin
                    alu_result = MAX;
                    alu_err    = 1'b1;
                end else begin
                    alu_result = sum[WIDTH-1:0];
                end
            end
            2'b01: begin
                if (b_reg > a_reg) begin
                    alu_result = '0;
                    alu_err    = 1'b1;
                end else begin
                    alu_result = a_reg - b_reg;
                end
            end
            2'b10: begin
                if (prod[2*WIDTH-1:WIDTH] != '0) begin
                    alu_result = MAX;
                    alu_err    = 1'b1;
                end else begin
                    alu_result = prod[WIDTH-1:0];
                end
            end
            default: begin
                // Only reached for divide by zero; a real divide goes to DIV.
                alu_result = MAX;
                alu_err    = 1'b1;
            end
        endcase
    end

    // Restoring division step: shift in the next dividend bit, try to subtract.
    // The partial remainder is always below B, so it fits in WIDTH bits.
    logic [WIDTH:0]   shifted, trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             last_step;

    assign shifted   = {rem_reg, quo_reg[WIDTH-1]};
    assign trial     = shifted - {1'b0, b_reg};
    assign q_bit     = ~trial[WIDTH];
    assign rem_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next  = {quo_reg[WIDTH-2:0], q_bit};
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state and busy output.
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg == DIV);
        if (clear_cmd) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (equals_cmd) state_next = div_start ? DIV : DONE;
                DIV:     if (last_step)  state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand, opcode, result and divider datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg           <= '0;
            b_reg           <= '0;
            r_reg           <= '0;
            opcode_reg      <= 2'b00;
            error_reg       <= 1'b0;
            valid_reg       <= 1'b0;
            set_q           <= 1'b0;
            clr_q           <= 1'b0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            cnt_reg         <= '0;
            div_pending_reg <= 1'b0;
        end else begin
            set_q <= memSet;
            clr_q <= memClr;
            if (clear_cmd) begin
                a_reg           <= '0;
                b_reg           <= '0;
                r_reg           <= '0;
                opcode_reg      <= 2'b00;
                error_reg       <= 1'b0;
                valid_reg       <= 1'b0;
                div_pending_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (equals_cmd) begin
                            if (div_start) begin
                                rem_reg   <= '0;
                                quo_reg   <= a_reg;
                                cnt_reg   <= '0;
                                valid_reg <= 1'b0;
                            end else begin
                                r_reg      <= alu_result;
                                error_reg  <= error_reg | alu_err;
                                valid_reg  <= 1'b1;
                                a_reg      <= '0;
                                b_reg      <= '0;
                                opcode_reg <= 2'b00;
                            end
                        end else if (write_cmd) begin
                            case (memLoc)
                                2'b00, 2'b01: begin
                                    if (digit_ok) begin
                                        if (!digit_fits) begin
                                            error_reg <= 1'b1;
                                        end else if (memLoc[0]) begin
                                            b_reg <= digit_t[WIDTH-1:0];
                                        end else begin
                                            a_reg <= digit_t[WIDTH-1:0];
                                        end
                                        if (!memLoc[0]) valid_reg <= 1'b0;
                                    end
                                end
                                2'b10:   opcode_reg <= keyValue[1:0];
                                default: ;
                            endcase
                        end
                    end
                    DIV: begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        cnt_reg <= cnt_reg + CW'(1);
                        if (last_step) div_pending_reg <= 1'b1;
                    end
                    DONE: begin
                        if (div_pending_reg) begin
                            r_reg           <= quo_reg;
                            valid_reg       <= 1'b1;
                            a_reg           <= '0;
                            b_reg           <= '0;
                            div_pending_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Display mux: a fresh result overrides the selector.
    always_comb begin
        dispValue = r_reg;
        if (!valid_reg) begin
            case (memDisplay)
                2'b00:   dispValue = a_reg;
                2'b01:   dispValue = b_reg;
                2'b10:   dispValue = WIDTH'(opcode_reg);
                default: dispValue = r_reg;
            endcase
        end
    end

    assign opcode      = opcode_reg;
    assign resultValid = valid_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_calc_memory.sv
// Self-checking bench for calc_memory: directed scenarios plus randomized
// calculations compared against an arithmetic reference model.
module tb_calc_memory;

    localparam int WIDTH = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             memClr;
    logic             memSet;
    logic [1:0]       memLoc;
    logic [1:0]       memDisplay;
    logic [3:0]       keyValue;
    logic [WIDTH-1:0] dispValue;
    logic [1:0]       opcode;
    logic             busy;
    logic             resultValid;
    logic             error;

    int checks   = 0;
    int failures = 0;

    // Reference model state, plain integers.
    int m_a, m_b, m_op, m_r, m_err, m_valid;

    calc_memory #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .memClr     (memClr),
        .memSet     (memSet),
        .memLoc     (memLoc),
        .memDisplay (memDisplay),
        .keyValue   (keyValue),
        .dispValue  (dispValue),
        .opcode     (opcode),
        .busy       (busy),
        .resultValid(resultValid),
        .error      (error)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void m_clear();
        m_a = 0; m_b = 0; m_op = 0; m_r = 0; m_err = 0; m_valid = 0;
    endfunction

    function automatic void m_digit(input int loc, input int key);
        int t;
        if (key > 9) return;
        t = ((loc == 0) ? m_a : m_b) * 10 + key;
        if (t > MAXV) m_err = 1;
        else if (loc == 0) m_a = t;
        else m_b = t;
        if (loc == 0) m_valid = 0;
    endfunction

    function automatic void m_equals();
        int v;
        case (m_op)
            0: begin v = m_a + m_b; if (v > MAXV) begin v = MAXV; m_err = 1; end end
            1: begin if (m_b > m_a) begin v = 0; m_err = 1; end else v = m_a - m_b; end
            2: begin v = m_a * m_b; if (v > MAXV) begin v = MAXV; m_err = 1; end end
            default: begin
                if (m_b == 0) begin v = MAXV; m_err = 1; end else v = m_a / m_b;
            end
        endcase
        m_r = v; m_valid = 1; m_a = 0; m_b = 0;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic press(input logic [1:0] loc, input logic [3:0] key);
        @(negedge clk);
        memLoc = loc; keyValue = key; memSet = 1'b1;
        @(negedge clk);
        memSet = 1'b0;
        @(negedge clk);
        $display("txn set   loc=%0d key=%0d disp=%0d err=%0d", loc, key, dispValue, error);
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        memLoc = 2'b00; memClr = 1'b1;
        @(negedge clk);
        memClr = 1'b0;
        @(negedge clk);
        $display("txn clear disp=%0d err=%0d", dispValue, error);
    endtask

    // Returns at the falling edge right after the committing rising edge.
    task automatic equals_raise();
        @(negedge clk);
        memLoc = 2'b11; memClr = 1'b1;
        @(negedge clk);
        memClr = 1'b0;
        $display("txn equals busy=%0d valid=%0d disp=%0d", busy, resultValid, dispValue);
    endtask

    task automatic enter_number(input logic [1:0] loc, input int value);
        if (value >= 100) press(loc, 4'((value / 100) % 10));
        if (value >= 10)  press(loc, 4'((value / 10) % 10));
        press(loc, 4'(value % 10));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset");
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 4; d++) begin
            memDisplay = 2'(d);
            #1;
            checks++;
            if (dispValue !== '0) begin
                failures++;
                $display("FAIL reset_disp sel=%0d got=%0d exp=0", d, dispValue);
            end
        end
        checks++;
        if ({opcode, busy, resultValid, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {opcode, busy, resultValid, error});
        end
    endtask

    task automatic test_digit_entry();
        press(2'b00, 4'd1); press(2'b00, 4'd2); press(2'b00, 4'd3);
        memDisplay = 2'b00; #1;
        checks++;
        if (dispValue !== 8'd123) begin
            failures++; $display("FAIL digit_a got=%0d exp=123", dispValue);
        end
        // Held memSet must commit only once.
        @(negedge clk);
        memLoc = 2'b01; keyValue = 4'd5; memSet = 1'b1;
        repeat (4) @(negedge clk);
        memSet = 1'b0;
        @(negedge clk);
        memDisplay = 2'b01; #1;
        checks++;
        if (dispValue !== 8'd5) begin
            failures++; $display("FAIL held_set got=%0d exp=5", dispValue);
        end
        checks++;
        if (error !== 1'b0) begin
            failures++; $display("FAIL digit_err got=%0d exp=0", error);
        end
    endtask

    task automatic test_overflow();
        clear_cmd();
        press(2'b00, 4'd2); press(2'b00, 4'd5); press(2'b00, 4'd6);
        memDisplay = 2'b00; #1;
        checks++;
        if (dispValue !== 8'd25 || error !== 1'b1) begin
            failures++; $display("FAIL overflow got=%0d/%0d exp=25/1", dispValue, error);
        end
        clear_cmd();
        press(2'b00, 4'd12);
        #1;
        checks++;
        if (dispValue !== 8'd0 || error !== 1'b0) begin
            failures++; $display("FAIL bad_key got=%0d/%0d exp=0/0", dispValue, error);
        end
    endtask

    task automatic test_add_sub();
        clear_cmd();
        enter_number(2'b00, 200); enter_number(2'b01, 100); press(2'b10, 4'd0);
        checks++;
        if (resultValid !== 1'b0) begin
            failures++; $display("FAIL add_pre_valid got=%0d exp=0", resultValid);
        end
        equals_raise();
        checks++;
        if (resultValid !== 1'b1 || dispValue !== 8'd255 || error !== 1'b1) begin
            failures++;
            $display("FAIL add_sat got=v%0d r%0d e%0d exp=v1 r255 e1", resultValid, dispValue, error);
        end
        clear_cmd();
        press(2'b00, 4'd7); press(2'b01, 4'd5); press(2'b10, 4'd1);
        equals_raise();
        checks++;
        if (resultValid !== 1'b1 || dispValue !== 8'd2 || error !== 1'b0 || opcode !== 2'b00) begin
            failures++;
            $display("FAIL sub got=v%0d r%0d e%0d op%0d exp=v1 r2 e0 op0",
                     resultValid, dispValue, error, opcode);
        end
        // A zero digit into A shows whether A was cleared (70 if not).
        press(2'b00, 4'd0);
        memDisplay = 2'b00; #1;
        checks++;
        if (resultValid !== 1'b0 || dispValue !== 8'd0) begin
            failures++; $display("FAIL sub_a_cleared got=v%0d a%0d exp=v0 a0", resultValid, dispValue);
        end
        memDisplay = 2'b01; #1;
        checks++;
        if (dispValue !== 8'd0) begin
            failures++; $display("FAIL sub_b_cleared got=%0d exp=0", dispValue);
        end
    endtask

    task automatic test_divide();
        clear_cmd();
        enter_number(2'b00, 200); enter_number(2'b01, 7); press(2'b10, 4'd3);
        memDisplay = 2'b11;
        equals_raise();
        for (int k = 0; k <= WIDTH + 1; k++) begin
            #1;
            checks++;
            if (busy !== ((k < WIDTH) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL div_busy cycle=%0d got=%0d", k, busy);
            end
            if (k == WIDTH) begin
                checks++;
                if (resultValid !== 1'b0) begin
                    failures++; $display("FAIL div_early_valid got=%0d exp=0", resultValid);
                end
            end
            if (k == WIDTH + 1) begin
                checks++;
                if (resultValid !== 1'b1 || dispValue !== 8'd28 || error !== 1'b0) begin
                    failures++;
                    $display("FAIL div_result got=v%0d r%0d e%0d exp=v1 r28 e0",
                             resultValid, dispValue, error);
                end
            end else begin
                @(negedge clk);
            end
        end
        clear_cmd();
        press(2'b00, 4'd9); press(2'b01, 4'd0); press(2'b10, 4'd3);
        equals_raise();
        checks++;
        if (resultValid !== 1'b1 || dispValue !== 8'd255 || error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL div_zero got=v%0d r%0d e%0d b%0d exp=v1 r255 e1 b0",
                     resultValid, dispValue, error, busy);
        end
    endtask

    task automatic start_divide();
        clear_cmd();
        enter_number(2'b00, 200); enter_number(2'b01, 7); press(2'b10, 4'd3);
        equals_raise();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_abort();
        // Writes while busy are dropped: quotient must stay 200/7.
        start_divide();
        press(2'b01, 4'd3);
        for (int c = 0; c < 3 * WIDTH && resultValid !== 1'b1; c++) @(negedge clk);
        memDisplay = 2'b11; #1;
        checks++;
        if (resultValid !== 1'b1 || dispValue !== 8'd28) begin
            failures++; $display("FAIL busy_drop got=v%0d r%0d exp=v1 r28", resultValid, dispValue);
        end
        // Clear aborts the divide.
        start_divide();
        clear_cmd();
        checks++;
        if ({opcode, busy, resultValid, error} !== 5'b0) begin
            failures++; $display("FAIL abort_flags got=%b exp=00000", {opcode, busy, resultValid, error});
        end
        repeat (2 * WIDTH) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            memDisplay = 2'(d); #1;
            checks++;
            if (dispValue !== '0 || resultValid !== 1'b0) begin
                failures++; $display("FAIL abort_disp sel=%0d got=%0d v=%0d exp=0", d, dispValue, resultValid);
            end
        end
        // Reset mid-divide.
        start_divide();
        do_reset();
        checks++;
        if ({opcode, busy, resultValid, error} !== 5'b0) begin
            failures++; $display("FAIL rst_div_flags got=%b exp=00000", {opcode, busy, resultValid, error});
        end
        repeat (2 * WIDTH) @(negedge clk);
        memDisplay = 2'b11; #1;
        checks++;
        if (dispValue !== '0 || resultValid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_div_after got=r%0d v%0d b%0d exp=0", dispValue, resultValid, busy);
        end
    endtask

    task automatic test_simultaneous();
        clear_cmd();
        press(2'b00, 4'd3);
        @(negedge clk);
        memLoc = 2'b00; keyValue = 4'd7; memSet = 1'b1; memClr = 1'b1;
        @(negedge clk);
        memSet = 1'b0; memClr = 1'b0;
        @(negedge clk);
        $display("txn set+clear loc=0 key=7 disp=%0d", dispValue);
        memDisplay = 2'b00; #1;
        checks++;
        if (dispValue !== 8'd0 || error !== 1'b0) begin
            failures++; $display("FAIL simultaneous got=%0d/%0d exp=0/0", dispValue, error);
        end
    endtask

    task automatic test_random();
        int na, nb, key, op;
        for (int it = 0; it < 25; it++) begin
            clear_cmd();
            m_clear();
            na = $urandom_range(1, 3);
            nb = $urandom_range(1, 3);
            for (int i = 0; i < na; i++) begin
                key = $urandom_range(0, 11);
                press(2'b00, 4'(key));
                m_digit(0, key);
                memDisplay = 2'b00; #1;
                checks++;
                if (int'(dispValue) !== m_a || int'(error) !== m_err) begin
                    failures++; $display("FAIL rnd_a it=%0d got=%0d/%0d exp=%0d/%0d", it, dispValue, error, m_a, m_err);
                end
            end
            for (int i = 0; i < nb; i++) begin
                key = $urandom_range(0, 11);
                press(2'b01, 4'(key));
                m_digit(1, key);
                memDisplay = 2'b01; #1;
                checks++;
                if (int'(dispValue) !== m_b || int'(error) !== m_err) begin
                    failures++; $display("FAIL rnd_b it=%0d got=%0d/%0d exp=%0d/%0d", it, dispValue, error, m_b, m_err);
                end
            end
            op = $urandom_range(0, 3);
            press(2'b10, 4'(op));
            m_op = op;
            checks++;
            if (int'(opcode) !== m_op) begin
                failures++; $display("FAIL rnd_op it=%0d got=%0d exp=%0d", it, opcode, m_op);
            end
            m_equals();
            equals_raise();
            for (int c = 0; c < 3 * WIDTH && resultValid !== 1'b1; c++) @(negedge clk);
            #1;
            checks++;
            if (resultValid !== 1'b1 || int'(dispValue) !== m_r || int'(error) !== m_err || busy !== 1'b0) begin
                failures++;
                $display("FAIL rnd_result it=%0d op=%0d got=v%0d r%0d e%0d b%0d exp=v1 r%0d e%0d b0",
                         it, op, resultValid, dispValue, error, busy, m_r, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; memClr = 1'b0; memSet = 1'b0;
        memLoc = 2'b00; memDisplay = 2'b00; keyValue = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_digit_entry();
        test_overflow();
        test_add_sub();
        test_divide();
        test_busy_abort();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_memory.md
Name: calc_memory

Overview:
- Storage and execute end of the controller-to-memory interface in the keypad calculator.
- Consumes the controller's memClr/memSet/memLoc/memDisplay commands together with the current key value.
- Builds decimal operands A and B digit by digit and holds the opcode.
- On "equals", computes the result R (add/sub/mul single-cycle, divide iterative) and drives the value selected for display.

Parameters:
- WIDTH, 8, operand/result width; MAX = 2^WIDTH-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- memClr  in  1  clear/equals command from controller (level).
- memSet  in  1  write command from controller (level).
- memLoc  in  2  target: 00 A digit, 01 B digit, 10 opcode, 11 equals.
- memDisplay  in  2  display select: 00 A, 01 B, 10 opcode, 11 R.
- keyValue  in  4  digit 0-9 for A/B writes; opcode in [1:0] for opcode writes.
- dispValue  out  WIDTH  selected register value.
- opcode  out  2  stored opcode: 00 add, 01 sub, 10 mul, 11 div.
- busy  out  1  divide in progress.
- resultValid  out  1  R holds a fresh result.
- error  out  1  sticky: entry overflow, sub underflow, mul overflow, or divide by zero.

Behaviour:
- Reset: A=B=R=0, opcode=00, busy=0, resultValid=0, error=0, dispValue=0. Edge-detect flops set_q=clr_q=0. FSM=IDLE.
- Commands are edge-triggered. A write commits at the posedge where memSet=1 and set_q=0. A clear/equals commits where memClr=1 and clr_q=0. A held level never re-fires. set_q/clr_q update every cycle, including while busy.
- FSM states: IDLE, DIV, DONE.
- Digit write, IDLE only (memLoc 00 or 01):
  - If keyValue>9, ignore.
  - Else compute t = reg*10 + keyValue at 2*WIDTH+4 bits.
  - If t<=MAX, reg<=t; otherwise reg unchanged and error<=1.
  - Any digit write to A clears resultValid.
  - Update visible the cycle after the commit edge.
- Opcode write (memLoc 10): opcode<=keyValue[1:0].
- memSet edge with memLoc 11: no effect.
- Clear (memClr edge, memLoc!=11): A, B, R, opcode, error, resultValid all go to 0. A clear during DIV aborts the divide, busy<=0, FSM=IDLE.
- Equals (memClr edge, memLoc 11, IDLE):
  - add: R=A+B; if the sum exceeds MAX, R=MAX and error=1.
  - sub: R=A-B; if B>A, R=0 and error=1.
  - mul: R=A*B; if the product exceeds MAX, R=MAX and error=1.
  - For add/sub/mul, R and resultValid=1 are visible 1 cycle after the edge. Then A=B=0, opcode=00. FSM passes through DONE for one cycle, then IDLE.
  - div with B=0: R=MAX, error=1, resultValid=1, same 1-cycle latency.
  - div with B!=0: enter DIV, busy=1. Restoring shift-subtract, one quotient bit per cycle, WIDTH cycles. Then DONE: R=quotient (remainder discarded), resultValid=1, busy=0, A=B=0.
  - Total divide latency is WIDTH+1 cycles from the edge to resultValid.
- While busy: all memSet/memClr edges are dropped, except a clear with memLoc!=11.
- Equals edge during DIV: ignored.
- memSet and memClr edges in the same cycle: clear/equals wins; the write is dropped.
- Display:
  - dispValue = R while resultValid=1.
  - Otherwise mux on memDisplay: 00 A, 01 B, 10 {0,opcode}, 11 R.
  - Combinational from registers; no extra latency.
- Reset mid-divide: returns to the full reset state next cycle.
- error stays set until a clear or reset.

Test Plan:
- Digit entry: reset; memSet edges, memLoc=00, keyValue 1,2,3 -> A=123. memDisplay=00 -> dispValue=123. Held memSet produces no extra writes.
- Overflow: A=25, enter digit 6 (256>255) -> A stays 25, error=1. keyValue=12 -> ignored.
- Add and saturate:
  - A=200, B=100, opcode 00, equals -> R=255, error=1, resultValid=1 one cycle later.
  - A=7, B=5, sub -> R=2, A=B=0.
- Divide:
  - A=200, B=7, opcode 11, equals -> busy=1 for 8 cycles, R=28 at cycle 9, busy=0.
  - A=9, B=0 -> R=255, error=1.
- Busy drop and abort:
  - During divide, digit write -> ignored.
  - During divide, memClr with memLoc=00 -> all 0, busy=0.
  - Reset mid-divide -> reset values.
- Simultaneous: memSet and memClr rise together with memLoc=00 -> clear applied, no digit written.
